inst_dispatch_ctrl: RTL and testbench
=====================================

// Module: inst_dispatch_ctrl
// PURPOSE
//  Issue scheduler between fetch and the scalar/vector pipes. Accepts one instruction per cycle
//  (valid/ready), classifies it, and drives registered scalar/vector instruction words and the
//  mode select. Vector ops hold the vector unit for VEC_LAT cycles. A second vector op stalls
//  until the unit frees. Scalar ops keep issuing meanwhile. Idle pipes receive their NOP words.
// PARAMETERS
//  VEC_LAT    4             cycles a vector op occupies the vector unit (>=1)
//  NOP_S      32'h2000_0000 scalar-pipe NOP (addi zero)
//  NOP_V      32'h1C00_0000 vector-pipe NOP
//  ADDI_HI    12'h200       upper 12 bits of the scalar companion for a vector op
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  inst_valid  in   1   fetch presents an instruction
//  inst        in   32  fetched instruction
//  inst_ready  out  1   combinational; instruction accepted when inst_valid && inst_ready
//  flush       in   1   branch redirect; discard the current fetch slot
//  inst_s      out  32  registered word to the scalar pipe
//  inst_v      out  32  registered word to the vector pipe
//  inst_selec  out  1   registered; 1 = the issued op is vector
//  vec_busy    out  1   registered; vector unit occupied
//  stall_cnt   out  16  registered; count of cycles with inst_valid && !inst_ready, saturating
// BEHAVIOUR
//  Reset: inst_s=NOP_S, inst_v=NOP_V, inst_selec=0, vec_busy=0, stall_cnt=0, vec_cnt=0, state=IDLE.
//  Classify: is_vec = (inst[31:29]==3'b100) || (inst[31:29]==3'b101). Every other opcode is scalar.
//  Ready: inst_ready = !flush && !(is_vec && vec_cnt>1).
//    Scalar ops are never stalled.
//  Latency: 1 cycle. An accept in cycle N shows on the outputs in cycle N+1.
//    Scalar accept: inst_s=inst, inst_v=NOP_V, inst_selec=0.
//    Vector accept: inst_s={ADDI_HI, inst[19:0]}, inst_v=inst, inst_selec=1.
//    No accept (idle, stall or flush): inst_s=NOP_S, inst_v=NOP_V, inst_selec=0.
//  vec_cnt (width clog2(VEC_LAT+1)):
//    On vector accept, load VEC_LAT.
//    Otherwise, if vec_cnt != 0, decrement.
//    vec_busy = (vec_cnt != 0), taken from the registered count.
//    vec_busy is high for exactly VEC_LAT cycles after an accept.
//  Back-to-back vector ops:
//    A new vector op is accepted in the last busy cycle (vec_cnt==1).
//    The reload takes priority over the decrement, so issue spacing is exactly VEC_LAT cycles.
//  VEC_LAT=1: vector ops never stall.
//  FSM:
//    IDLE -> VBUSY on vector accept.
//    VBUSY -> IDLE when vec_cnt==1 and no vector accept.
//    VBUSY -> VBUSY on a reload.
//  Flush:
//    Forces inst_ready=0 and NOP outputs on the next cycle.
//    Does not touch vec_cnt. An in-flight vector op completes.
//    Does not increment stall_cnt.
//  stall_cnt: increments when inst_valid && !inst_ready && !flush. Holds at 16'hFFFF.
//  Reset mid-operation: all state returns to reset values immediately (asynchronous).
//    The in-flight vector occupancy is dropped.
// TESTING
//  1 Reset asserted, then released, inst_valid=0 -> inst_s=2000_0000, inst_v=1C00_0000, selec=0, vec_busy=0,
//    stall_cnt=0, inst_ready=1.
//  2 Scalar 2001_0005 valid for 1 cycle -> next cycle inst_s=2001_0005, inst_v=1C00_0000, selec=0;
//    cycle after that, NOPs again.
//  3 Vector 8012_3456 -> next cycle inst_s=2002_3456, inst_v=8012_3456, selec=1;
//    vec_busy high for exactly 4 cycles.
//  4 Two vector ops 8000_0001 and A000_0002 presented back-to-back (VEC_LAT=4) -> second issues
//    4 cycles after the first; inst_ready low for 3 cycles; stall_cnt=3.
//  5 Vector op, then scalar 2000_0007 on the next cycle -> scalar issues immediately with vec_busy=1;
//    stall_cnt unchanged.
//  6 flush asserted with a valid vector op while vec_busy=1 -> no accept, NOP outputs, stall_cnt
//    unchanged, vec_busy ends on schedule.
//    Then rst pulsed mid-busy -> vec_busy=0 and outputs at NOPs asynchronously.

Source files
------------

// File: rtl/inst_dispatch_ctrl_if.sv
// Fetch-to-dispatch handshake plus the registered issue outputs toward the scalar/vector pipes.
// The master side is the fetch/observer end; the slave side is the dispatch controller.
interface inst_dispatch_ctrl_if;
   logic        inst_valid;
   logic [31:0] inst;
   logic        inst_ready;
   logic        flush;
   logic [31:0] inst_s;
   logic [31:0] inst_v;
   logic        inst_selec;
   logic        vec_busy;
   logic [15:0] stall_cnt;

   modport master (
      output inst_valid,
      output inst,
      output flush,
      input  inst_ready,
      input  inst_s,
      input  inst_v,
      input  inst_selec,
      input  vec_busy,
      input  stall_cnt
   );

   modport slave (
      input  inst_valid,
      input  inst,
      input  flush,
      output inst_ready,
      output inst_s,
      output inst_v,
      output inst_selec,
      output vec_busy,
      output stall_cnt
   );
endinterface

// File: rtl/inst_dispatch_ctrl.sv
// Issue scheduler: classifies each fetched instruction and issues it to the scalar or vector pipe,
// holding off a second vector op until the vector unit reaches its last busy cycle.
module inst_dispatch_ctrl #(
   parameter int unsigned VEC_LAT = 4,
   parameter logic [31:0] NOP_S   = 32'h2000_0000,
   parameter logic [31:0] NOP_V   = 32'h1C00_0000,
   parameter logic [11:0] ADDI_HI = 12'h200
) (
   input  logic clk,
   input  logic rst,
   inst_dispatch_ctrl_if.slave bus
);

   localparam int CW = $clog2(VEC_LAT + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(VEC_LAT);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic {IDLE, VBUSY} state_t;

   state_t        state;
   logic [CW-1:0] vec_cnt;
   logic          is_vec;
   logic          accept;
   logic          vec_accept;
   logic          stall_evt;

   // Opcodes 100 and 101 share the prefix 10, so a two-bit compare classifies vector ops.
   assign is_vec         = (bus.inst[31:30] == 2'b10);
   assign bus.inst_ready = !bus.flush && !(is_vec && (vec_cnt > CNT_ONE));
   assign accept         = bus.inst_valid && bus.inst_ready;
   assign vec_accept     = accept && is_vec;
   assign stall_evt      = bus.inst_valid && !bus.inst_ready && !bus.flush;

   // vec_busy is registered from the next count, so it tracks vec_cnt != 0 exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         vec_cnt        <= '0;
         bus.inst_s     <= NOP_S;
         bus.inst_v     <= NOP_V;
         bus.inst_selec <= 1'b0;
         bus.vec_busy   <= 1'b0;
         bus.stall_cnt  <= 16'h0000;
      end else begin
         if (vec_accept) begin
            vec_cnt <= CNT_LOAD;
         end else if (vec_cnt != '0) begin
            vec_cnt <= vec_cnt - CNT_ONE;
         end
         bus.vec_busy <= vec_accept || (vec_cnt > CNT_ONE);

         if (vec_accept) begin
            bus.inst_s     <= {ADDI_HI, bus.inst[19:0]};
            bus.inst_v     <= bus.inst;
            bus.inst_selec <= 1'b1;
         end else if (accept) begin
            bus.inst_s     <= bus.inst;
            bus.inst_v     <= NOP_V;
            bus.inst_selec <= 1'b0;
         end else begin
            bus.inst_s     <= NOP_S;
            bus.inst_v     <= NOP_V;
            bus.inst_selec <= 1'b0;
         end

         if (stall_evt && (bus.stall_cnt != 16'hFFFF)) begin
            bus.stall_cnt <= bus.stall_cnt + 16'h0001;
         end

         case (state)
            IDLE: begin
               if (vec_accept) begin
                  state <= VBUSY;
               end
            end
            VBUSY: begin
               if (!vec_accept && (vec_cnt == CNT_ONE)) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_dispatch_ctrl.sv
// Self-checking bench for inst_dispatch_ctrl: directed scenarios followed by random traffic,
// checked against a timestamp-based model of vector-unit occupancy.
module tb_inst_dispatch_ctrl;

   localparam int          VEC_LAT = 4;
   localparam logic [31:0] NOP_S   = 32'h2000_0000;
   localparam logic [31:0] NOP_V   = 32'h1C00_0000;
   localparam logic [11:0] ADDI_HI = 12'h200;

   logic clk;
   logic rst;

   inst_dispatch_ctrl_if bus ();

   inst_dispatch_ctrl #(
      .VEC_LAT(VEC_LAT),
      .NOP_S  (NOP_S),
      .NOP_V  (NOP_V),
      .ADDI_HI(ADDI_HI)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_pass;

   // Model state: cycle index, and the cycle in which the most recent vector op was accepted.
   int          cyc;
   bit          have_vec;
   int          last_vec_cyc;
   logic [31:0] exp_s;
   logic [31:0] exp_v;
   logic        exp_sel;
   logic [15:0] exp_stall;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   function automatic bit modelVecBusy();
      return have_vec && (cyc - last_vec_cyc >= 1) && (cyc - last_vec_cyc <= VEC_LAT);
   endfunction

   function automatic bit modelReady(input logic [31:0] w, input logic f);
      bit isv;
      bit blocked;
      isv     = (w[31:29] == 3'b100) || (w[31:29] == 3'b101);
      blocked = isv && have_vec && (cyc - last_vec_cyc < VEC_LAT);
      return !f && !blocked;
   endfunction

   task automatic modelReset();
      cyc       = 0;
      have_vec  = 1'b0;
      last_vec_cyc = 0;
      exp_s     = NOP_S;
      exp_v     = NOP_V;
      exp_sel   = 1'b0;
      exp_stall = 16'h0000;
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".inst_s"},     bus.inst_s,             exp_s);
      checkOutput({tag, ".inst_v"},     bus.inst_v,             exp_v);
      checkOutput({tag, ".inst_selec"}, {31'd0, bus.inst_selec}, {31'd0, exp_sel});
      checkOutput({tag, ".vec_busy"},   {31'd0, bus.vec_busy},   {31'd0, modelVecBusy()});
      checkOutput({tag, ".stall_cnt"},  {16'd0, bus.stall_cnt}, {16'd0, exp_stall});
   endtask

   // One cycle: drive inputs just after the edge, check ready, advance the model across the edge.
   task automatic applyStimulus(input string tag, input logic v, input logic [31:0] w, input logic f);
      bit rdy;
      bit isv;
      bus.inst_valid = v;
      bus.inst       = w;
      bus.flush      = f;
      #1;
      rdy = modelReady(w, f);
      isv = (w[31:29] == 3'b100) || (w[31:29] == 3'b101);
      checkOutput({tag, ".inst_ready"}, {31'd0, bus.inst_ready}, {31'd0, rdy});
      if (v && rdy) begin
         if (isv) begin
            exp_s        = {ADDI_HI, w[19:0]};
            exp_v        = w;
            exp_sel      = 1'b1;
            have_vec     = 1'b1;
            last_vec_cyc = cyc;
         end else begin
            exp_s   = w;
            exp_v   = NOP_V;
            exp_sel = 1'b0;
         end
      end else begin
         exp_s   = NOP_S;
         exp_v   = NOP_V;
         exp_sel = 1'b0;
      end
      if (v && !rdy && !f && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      @(posedge clk);
      #1;
      cyc++;
      checkAll(tag);
   endtask

   initial begin
      logic [31:0] r;
      logic [2:0]  top;
      logic        rv;
      logic        rf;
      n_checks = 0;
      n_pass   = 0;
      modelReset();

      // Reset and release with nothing presented.
      rst            = 1'b1;
      bus.inst_valid = 1'b0;
      bus.inst       = 32'h0;
      bus.flush      = 1'b0;
      #12;
      checkAll("reset_hold");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkAll("reset_release");
      checkOutput("reset_ready", {31'd0, bus.inst_ready}, 32'd1);

      // Single scalar op then idle.
      applyStimulus("scalar_issue", 1'b1, 32'h2001_0005, 1'b0);
      checkOutput("scalar_word", bus.inst_s, 32'h2001_0005);
      applyStimulus("scalar_after", 1'b0, 32'h0, 1'b0);

      // Single vector op and its full occupancy window.
      applyStimulus("vec_issue", 1'b1, 32'h8012_3456, 1'b0);
      checkOutput("vec_companion", bus.inst_s, 32'h2002_3456);
      repeat (VEC_LAT) applyStimulus("vec_window", 1'b0, 32'h0, 1'b0);
      checkOutput("vec_window_end", {31'd0, bus.vec_busy}, 32'd0);

      // Back-to-back vector ops: second one waits for the last busy cycle.
      applyStimulus("b2b_first", 1'b1, 32'h8000_0001, 1'b0);
      repeat (VEC_LAT) applyStimulus("b2b_second", 1'b1, 32'hA000_0002, 1'b0);
      checkOutput("b2b_second_word", bus.inst_v, 32'hA000_0002);
      checkOutput("b2b_stalls", {16'd0, bus.stall_cnt}, 32'd3);
      repeat (VEC_LAT) applyStimulus("b2b_drain", 1'b0, 32'h0, 1'b0);

      // Scalar op issues while the vector unit is busy.
      applyStimulus("mix_vec", 1'b1, 32'h8000_0003, 1'b0);
      applyStimulus("mix_scalar", 1'b1, 32'h2000_0007, 1'b0);
      checkOutput("mix_scalar_busy", {31'd0, bus.vec_busy}, 32'd1);
      repeat (VEC_LAT) applyStimulus("mix_drain", 1'b0, 32'h0, 1'b0);

      // Flush with a pending vector op while busy, then an asynchronous reset mid-busy.
      applyStimulus("flush_vec", 1'b1, 32'h8000_0004, 1'b0);
      applyStimulus("flush_pending", 1'b1, 32'hA000_0009, 1'b1);
      repeat (VEC_LAT) applyStimulus("flush_drain", 1'b0, 32'h0, 1'b0);
      applyStimulus("pre_rst_vec", 1'b1, 32'hA000_0011, 1'b0);
      applyStimulus("pre_rst_idle", 1'b1, 32'h8000_0012, 1'b0);
      bus.inst_valid = 1'b0;
      bus.flush      = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      modelReset();
      checkAll("async_rst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkAll("async_rst_release");

      // Random traffic biased toward vector ops.
      for (int i = 0; i < 400; i++) begin
         r   = $urandom();
         top = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) top = {2'b10, top[0]};
         rv  = ($urandom_range(0, 3) != 0);
         rf  = ($urandom_range(0, 9) == 0);
         applyStimulus("random", rv, {top, r[28:0]}, rf);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
